// File: rtl/pipelined_subtractor_16bit_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipelined_subtractor_16bit_if
//  Description : Operand/result handshake bundle for the pipelined subtractor.
//                The master drives operands and consumes results; the slave
//                is the subtractor itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipelined_subtractor_16bit_if #(
   parameter int WIDTH = 16
) ();
   // Operand side
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   // Result side
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] diff;
   logic             bout;
   logic             ovf;
   logic             zero;

   modport master (
      output in_valid, a, b, bin, out_ready,
      input  in_ready, out_valid, diff, bout, ovf, zero
   );

   modport slave (
      input  in_valid, a, b, bin, out_ready,
      output in_ready, out_valid, diff, bout, ovf, zero
   );
endinterface
`default_nettype wire

// File: rtl/pipelined_subtractor_16bit.sv
`default_nettype none
// ============================================================================
//  Module      : pipelined_subtractor_16bit
//  Description : Pipelined two's-complement subtractor, diff = a - b - bin.
//                Each stage resolves one SLICE-bit lookahead slice of
//                a + ~b + cin; the carry ripples between stages through
//                registers. Valid/ready handshake on both ends, one operation
//                per cycle, latency WIDTH/SLICE cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipelined_subtractor_16bit #(
   parameter int WIDTH = 16,
   parameter int SLICE = 4
) (
   input  wire logic                    clk,
   input  wire logic                    rst,
   pipelined_subtractor_16bit_if.slave  bus
);

   localparam int STAGES = WIDTH / SLICE;

   // Ready chain: w_ready[k] is the readiness of stage k, w_ready[STAGES]
   // is the downstream consumer. A stage may load when it is empty or when
   // its own content leaves in the same cycle.
   logic [STAGES:0]   w_ready;
   logic [STAGES-1:0] w_valid;

   assign w_ready[STAGES] = bus.out_ready;
   assign bus.in_ready    = w_ready[0];

   // One slice of a + ~b + cin with full carry lookahead; returns {cout, sum}.
   function automatic logic [SLICE:0] f_sub_slice(
      input logic [SLICE-1:0] a_s,
      input logic [SLICE-1:0] b_s,
      input logic             cin
   );
      logic [SLICE-1:0] p;
      logic [SLICE-1:0] g;
      logic [SLICE:0]   c;
      logic             term;
      p    = a_s ^ ~b_s;
      g    = a_s & ~b_s;
      c    = '0;
      c[0] = cin;
      // c[i+1] = p[i:0]&cin | g[0]&p[i:1] | ... | g[i], each term flat
      for (int i = 0; i < SLICE; i++) begin
         term = cin;
         for (int j = 0; j <= i; j++) begin
            term = term & p[j];
         end
         c[i+1] = term;
         for (int j = 0; j <= i; j++) begin
            term = g[j];
            for (int m = j + 1; m <= i; m++) begin
               term = term & p[m];
            end
            c[i+1] = c[i+1] | term;
         end
      end
      return {c[SLICE], p ^ c[SLICE-1:0]};
   endfunction

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      // RW: operand bits still to be processed on entry to this stage.
      // DW: result bits known once this stage has resolved its slice.
      localparam int RW = WIDTH - SLICE * k;
      localparam int DW = SLICE * (k + 1);

      logic          w_up_valid;
      logic [RW-1:0] w_a_rem;
      logic [RW-1:0] w_b_rem;
      logic          w_cin;
      logic [SLICE:0] w_slice;
      logic [DW-1:0] w_diff_d;
      logic          w_load;
      logic          r_valid_q;
      logic [DW-1:0] r_diff_q;

      if (k == 0) begin : g_src_in
         // First slice: borrow-in enters as an inverted carry.
         assign w_up_valid = bus.in_valid;
         assign w_a_rem    = bus.a;
         assign w_b_rem    = bus.b;
         assign w_cin      = ~bus.bin;
         assign w_diff_d   = w_slice[SLICE-1:0];
      end else begin : g_src_stage
         assign w_up_valid = w_valid[k-1];
         assign w_a_rem    = g_stage[k-1].g_fwd.r_a_q;
         assign w_b_rem    = g_stage[k-1].g_fwd.r_b_q;
         assign w_cin      = g_stage[k-1].g_fwd.r_carry_q;
         assign w_diff_d   = {w_slice[SLICE-1:0], g_stage[k-1].r_diff_q};
      end

      assign w_slice    = f_sub_slice(w_a_rem[SLICE-1:0], w_b_rem[SLICE-1:0], w_cin);
      assign w_ready[k] = ~r_valid_q | w_ready[k+1];
      assign w_valid[k] = r_valid_q;
      // Data only moves when a real operation arrives; a bubble just clears valid.
      assign w_load     = w_ready[k] & w_up_valid;

      // Stage occupancy: take the upstream valid whenever this stage can move.
      always_ff @(posedge clk) begin
         if (rst) begin
            r_valid_q <= 1'b0;
         end else if (w_ready[k]) begin
            r_valid_q <= w_up_valid;
         end
      end

      // Accumulated low result bits, extended by this stage's slice.
      always_ff @(posedge clk) begin
         if (rst) begin
            r_diff_q <= '0;
         end else if (w_load) begin
            r_diff_q <= w_diff_d;
         end
      end

      if (k < STAGES - 1) begin : g_fwd
         logic [RW-SLICE-1:0] r_a_q;
         logic [RW-SLICE-1:0] r_b_q;
         logic                r_carry_q;

         // Forward the unprocessed operand bits and this slice's carry.
         always_ff @(posedge clk) begin
            if (rst) begin
               r_a_q     <= '0;
               r_b_q     <= '0;
               r_carry_q <= 1'b0;
            end else if (w_load) begin
               r_a_q     <= w_a_rem[RW-1:SLICE];
               r_b_q     <= w_b_rem[RW-1:SLICE];
               r_carry_q <= w_slice[SLICE];
            end
         end
      end else begin : g_last
         logic w_ovf_d;
         logic w_zero_d;
         logic r_bout_q;
         logic r_ovf_q;
         logic r_zero_q;

         // Overflow when operand signs differ and the result sign differs from a.
         assign w_ovf_d  = (w_a_rem[RW-1] ^ w_b_rem[RW-1]) & (w_a_rem[RW-1] ^ w_diff_d[DW-1]);
         assign w_zero_d = ~|w_diff_d;

         // Result flags: final carry inverted gives the unsigned borrow.
         always_ff @(posedge clk) begin
            if (rst) begin
               r_bout_q <= 1'b0;
               r_ovf_q  <= 1'b0;
               r_zero_q <= 1'b0;
            end else if (w_load) begin
               r_bout_q <= ~w_slice[SLICE];
               r_ovf_q  <= w_ovf_d;
               r_zero_q <= w_zero_d;
            end
         end

         assign bus.out_valid = r_valid_q;
         assign bus.diff      = r_diff_q;
         assign bus.bout      = r_bout_q;
         assign bus.ovf       = r_ovf_q;
         assign bus.zero      = r_zero_q;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pipelined_subtractor_16bit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipelined_subtractor_16bit
//  Description : Self-checking bench for pipelined_subtractor_16bit. Expected
//                results come from plain integer arithmetic held in an
//                in-order queue; directed cases pin latency and flag values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_subtractor_16bit;

   localparam int WIDTH  = 16;
   localparam int SLICE  = 4;
   localparam int STAGES = WIDTH / SLICE;

   typedef struct packed {
      logic [WIDTH-1:0] diff;
      logic             bout;
      logic             ovf;
      logic             zero;
   } res_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pipelined_subtractor_16bit_if #(.WIDTH(WIDTH)) bus ();

   pipelined_subtractor_16bit #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int   total = 0;
   int   bad   = 0;
   res_t exp_q[$];
   int   n_emit = 0;
   bit   acc;

   // Drive state applied at each falling edge
   logic             d_rst   = 1'b1;
   logic             d_valid = 1'b0;
   logic [WIDTH-1:0] d_a     = '0;
   logic [WIDTH-1:0] d_b     = '0;
   logic             d_bin   = 1'b0;
   logic             d_ready = 1'b0;

   initial begin
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.bin       = 1'b0;
      bus.out_ready = 1'b0;
   end

   // Reference: plain integer subtraction, range checks for the flags
   function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic bin);
      res_t r;
      int ua, ub, bi, ud, sa, sb, sd;
      ua = int'(a);
      ub = int'(b);
      bi = int'(bin);
      ud = ua - ub - bi;
      sa = int'($signed(a));
      sb = int'($signed(b));
      sd = sa - sb - bi;
      r.diff = ud[WIDTH-1:0];
      r.bout = (ua < ub + bi);
      r.ovf  = (sd > (2 ** (WIDTH - 1)) - 1) || (sd < -(2 ** (WIDTH - 1)));
      r.zero = (r.diff == '0);
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, want, $time);
      end
   endtask

   function automatic res_t dut_res();
      res_t r;
      r.diff = bus.diff;
      r.bout = bus.bout;
      r.ovf  = bus.ovf;
      r.zero = bus.zero;
      return r;
   endfunction

   // One cycle: apply drive after the falling edge, then check and account
   // for the transfers that the next rising edge will perform.
   task automatic tick();
      res_t front;
      @(negedge clk);
      rst           = d_rst;
      bus.in_valid  = d_valid;
      bus.a         = d_a;
      bus.b         = d_b;
      bus.bin       = d_bin;
      bus.out_ready = d_ready;
      #1;
      acc = 1'b0;
      if (d_rst) begin
         exp_q.delete();
      end else begin
         if (bus.out_valid) begin
            if (exp_q.size() == 0) begin
               chk("spurious_out_valid", 32'(bus.out_valid), 32'd0);
            end else begin
               front = exp_q[0];
               chk("result", 32'(dut_res()), 32'(front));
               if (bus.out_ready) begin
                  void'(exp_q.pop_front());
                  n_emit++;
               end
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            exp_q.push_back(model(bus.a, bus.b, bus.bin));
            acc = 1'b1;
         end
      end
   endtask

   task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic bi, output bit ok);
      d_valid = 1'b1;
      d_a     = a;
      d_b     = b;
      d_bin   = bi;
      ok      = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (acc) begin
            ok = 1'b1;
            break;
         end
      end
      d_valid = 1'b0;
   endtask

   task automatic run_single(input string nm, input logic [WIDTH-1:0] a,
                             input logic [WIDTH-1:0] b, input logic bi, input res_t want);
      bit ok;
      int lat;
      chk({nm, "_model"}, 32'(model(a, b, bi)), 32'(want));
      d_ready = 1'b1;
      send(a, b, bi, ok);
      chk({nm, "_accepted"}, 32'(ok), 32'd1);
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!bus.out_valid && lat < 20);
      chk({nm, "_latency"}, lat, STAGES);
      chk({nm, "_value"}, 32'(dut_res()), 32'(want));
      tick();
      chk({nm, "_one_cycle"}, 32'(bus.out_valid), 32'd0);
   endtask

   function automatic logic [WIDTH-1:0] rand_operand();
      case ($urandom_range(0, 7))
         0:       return '0;
         1:       return '1;
         2:       return {1'b1, {(WIDTH-1){1'b0}}};
         3:       return {1'b0, {(WIDTH-1){1'b1}}};
         default: return WIDTH'($urandom);
      endcase
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      int i;
      int t;
      int start;
      res_t snap;
      logic [WIDTH-1:0] sa [8];
      logic [WIDTH-1:0] sb [8];
      logic             sbi [8];

      // Reset and the state in the first cycle after release
      d_rst = 1'b1;
      repeat (3) tick();
      d_rst = 1'b0;
      tick();
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_outputs", 32'(dut_res()), 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

      // Directed values
      run_single("basic",     16'h1234, 16'h0234, 1'b0, '{16'h1000, 1'b0, 1'b0, 1'b0});
      run_single("underflow", 16'h0000, 16'h0001, 1'b0, '{16'hFFFF, 1'b1, 1'b0, 1'b0});
      run_single("sovf",      16'h8000, 16'h0001, 1'b0, '{16'h7FFF, 1'b0, 1'b1, 1'b0});
      run_single("zero",      16'h5555, 16'h5554, 1'b1, '{16'h0000, 1'b0, 1'b0, 1'b1});
      run_single("eq_bin",    16'h00F0, 16'h00F0, 1'b1, '{16'hFFFF, 1'b1, 1'b0, 1'b0});

      // Eight back-to-back ops into a stalled consumer
      for (int k = 0; k < 8; k++) begin
         sa[k]  = rand_operand();
         sb[k]  = rand_operand();
         sbi[k] = 1'($urandom_range(0, 1));
      end
      d_ready = 1'b0;
      i = 0;
      for (int c = 0; c < 12; c++) begin
         if (i < 8) begin
            d_valid = 1'b1; d_a = sa[i]; d_b = sb[i]; d_bin = sbi[i];
         end
         tick();
         if (acc) i++;
      end
      chk("stall_accepts", i, 4);
      chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
      chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
      snap = dut_res();
      tick();
      tick();
      chk("stall_hold", 32'(dut_res()), 32'(snap));
      d_ready = 1'b1;
      start = n_emit;
      t = 0;
      while ((n_emit - start) < 8 && t < 30) begin
         if (i < 8) begin
            d_valid = 1'b1; d_a = sa[i]; d_b = sb[i]; d_bin = sbi[i];
         end else begin
            d_valid = 1'b0;
         end
         tick();
         if (acc) i++;
         t++;
      end
      d_valid = 1'b0;
      chk("stream_cycles", t, 8);
      chk("stream_all_accepted", i, 8);
      chk("stream_drained", exp_q.size(), 0);

      // Random traffic with a randomly stalling consumer
      i = 0;
      t = 0;
      while (i < 1000 && t < 20000) begin
         d_ready = ($urandom_range(0, 3) != 0);
         if (!d_valid && $urandom_range(0, 4) != 0) begin
            d_valid = 1'b1;
            d_a     = rand_operand();
            d_b     = ($urandom_range(0, 9) == 0) ? d_a : rand_operand();
            d_bin   = 1'($urandom_range(0, 1));
         end
         tick();
         t++;
         if (acc) begin
            i++;
            d_valid = 1'b0;
         end
      end
      d_valid = 1'b0;
      chk("random_accepts", i, 1000);
      d_ready = 1'b1;
      t = 0;
      while (exp_q.size() > 0 && t < 50) begin
         tick();
         t++;
      end
      chk("random_drained", exp_q.size(), 0);

      // Reset with three operations in flight
      d_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         send(rand_operand(), rand_operand(), 1'b0, ok);
         chk("inflight_accept", 32'(ok), 32'd1);
      end
      d_rst = 1'b1;
      tick();
      d_rst = 1'b0;
      tick();
      chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("midrst_outputs", 32'(dut_res()), 32'd0);
      chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
      t = 0;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (bus.out_valid) t++;
      end
      chk("midrst_discarded", t, 0);
      run_single("after_rst", 16'hABCD, 16'h1111, 1'b1, '{16'h9ABB, 1'b0, 1'b0, 1'b0});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
